// File: rtl/gpu_pkg.sv
// Shared definitions for the column renderer: record field layout, fetch FSM encoding.
// Latency: none (package only).
// Backpressure: none (package only).
package gpu_pkg;

  // Column record field widths; the record is packed {tex_id, half_h, uv_step}.
  localparam int TEX_W   = 2;
  localparam int HALF_W  = 8;
  localparam int STEP_W  = 8;
  localparam int UV_W    = 6;
  localparam int UV_FRAC = 4;
  localparam int ENTRY_W = TEX_W + HALF_W + STEP_W;

  // Field offsets inside a packed record.
  localparam int STEP_LSB = 0;
  localparam int HALF_LSB = STEP_W;
  localparam int TEX_LSB  = STEP_W + HALF_W;

  typedef struct packed {
    logic [TEX_W-1:0]  tex_id;
    logic [HALF_W-1:0] half_h;
    logic [STEP_W-1:0] uv_step;
  } entry_t;

  // Fetch FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
    entry_t e;
    e.tex_id  = raw[TEX_LSB  +: TEX_W];
    e.half_h  = raw[HALF_LSB +: HALF_W];
    e.uv_step = raw[STEP_LSB +: STEP_W];
    return e;
  endfunction

endpackage

// File: rtl/gpu_column_bank.sv
// Two-bank column record store: one write port, one registered read port, bank chosen per access.
// Latency: read data valid 1 clk after rd_en.
// Backpressure: none; caller guarantees addresses are below COLUMNS.
module gpu_column_bank
  import gpu_pkg::*;
#(
  parameter int COLUMNS = 320,
  parameter int AW      = $clog2(COLUMNS)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic               wr_bank,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic               rd_bank,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  localparam int IW = $clog2(2 * COLUMNS);

  // Both banks share one flat array: bank 1 lives above bank 0.
  logic [ENTRY_W-1:0] mem [2*COLUMNS];
  logic [IW-1:0]      wr_idx;
  logic [IW-1:0]      rd_idx;

  assign wr_idx = IW'(wr_addr) + (wr_bank ? IW'(COLUMNS) : IW'(0));
  assign rd_idx = IW'(rd_addr) + (rd_bank ? IW'(COLUMNS) : IW'(0));

  // CPU write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Registered read port feeding the prefetch ring.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/gpu_column_renderer.sv
// Turns per-column wall records into per-pixel wall/texture outputs from a double-buffered store.
// Latency: px_valid pulses 2 clk after pix_en; store reads 1 clk into a LOOKAHEAD-deep ring.
// Backpressure: none upstream; ring starvation is flagged by sticky underrun, pixel shown as sky.
module gpu_column_renderer
  import gpu_pkg::*;
#(
  parameter int COLUMNS   = 320,
  parameter int COL_SCALE = 2,
  parameter int ROW_SCALE = 2,
  parameter int LOOKAHEAD = 8,
  parameter int CENTER    = 120
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               pix_en,
  input  logic               line_start,
  input  logic               frame_start,
  input  logic               in_display,
  input  logic [9:0]         row,
  input  logic [9:0]         column,
  input  logic               wr_en,
  input  logic [8:0]         wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               swap_req,
  output logic               swap_pending,
  output logic               swap_ack,
  output logic               px_valid,
  output logic               px_inside,
  output logic [UV_W-1:0]    px_uv,
  output logic [TEX_W-1:0]   px_tex,
  output logic               underrun
);

  localparam int AW    = $clog2(COLUMNS);
  localparam int IDX_W = $clog2(COLUMNS + 1);
  localparam int LA_W  = $clog2(LOOKAHEAD);
  localparam int RS_SH = $clog2(ROW_SCALE);
  localparam int PW    = 12 + STEP_W;
  localparam logic [11:0]  CENTER_L = 12'(CENTER);
  localparam logic [PW-1:0] UV_MAX  = PW'((1 << UV_W) - 1);
  localparam logic [9:0]   COL_MASK = 10'(COL_SCALE - 1);

  // ---------------- front/back swap ----------------
  logic front_sel;
  logic swap_now;

  // A request made in the frame_start cycle itself is honoured immediately.
  assign swap_now = frame_start && (swap_pending || swap_req);

  // Swap bookkeeping; swap_ack is high in the first cycle the new front bank is live.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= swap_now;
      if (swap_now) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // ---------------- column store ----------------
  logic               wr_ok;
  logic               issue;
  logic [IDX_W-1:0]   fetch_idx;
  logic [ENTRY_W-1:0] rd_data;

  // Out-of-range writes are dropped so they cannot alias into the other bank.
  assign wr_ok = wr_en && (wr_addr < 9'(COLUMNS));

  gpu_column_bank #(
    .COLUMNS (COLUMNS),
    .AW      (AW)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_bank (~front_sel),
    .wr_addr (AW'(wr_addr)),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_bank (front_sel),
    .rd_addr (AW'(fetch_idx)),
    .rd_data (rd_data)
  );

  // ---------------- fetch FSM ----------------
  logic [1:0]      state;
  logic            rd_vld;
  logic [LA_W:0]   ring_cnt;
  logic [LA_W:0]   occ;
  logic            room;
  logic            more;

  // Occupancy counts the read already in flight so the ring never overfills.
  assign occ   = ring_cnt + {{LA_W{1'b0}}, rd_vld};
  assign room  = occ < (LA_W + 1)'(LOOKAHEAD);
  assign more  = fetch_idx != IDX_W'(COLUMNS);
  assign issue = !line_start && ((state == ST_FILL) || (state == ST_STREAM)) && more && room;

  // Fetch sequencing; line_start restarts from column 0 in any state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_IDLE;
      fetch_idx <= '0;
      rd_vld    <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (line_start) begin
        state     <= ST_FILL;
        fetch_idx <= '0;
      end else begin
        if (issue) fetch_idx <= fetch_idx + IDX_W'(1);
        case (state)
          ST_FILL:   if (!more) state <= ST_IDLE; else if (!room) state <= ST_STREAM;
          ST_STREAM: if (!more) state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------- prefetch ring ----------------
  logic [ENTRY_W-1:0] ring [LOOKAHEAD];
  logic [LA_W-1:0]    wp;
  logic [LA_W-1:0]    rp;
  logic               push;
  logic               pop;
  logic               pop_ok;
  logic               head_vld;
  entry_t             head;

  // A read landing on a line_start cycle belongs to the old line and is dropped.
  assign push     = rd_vld && !line_start;
  assign pop      = pix_en && in_display && ((column & COL_MASK) == COL_MASK);
  assign head_vld = ring_cnt != '0;
  assign pop_ok   = pop && head_vld;
  assign head     = unpack_entry(ring[rp]);

  // Ring payload; not reset, validity is tracked by ring_cnt.
  always_ff @(posedge clk) begin
    if (push) ring[wp] <= rd_data;
  end

  // Ring pointers, count and the sticky underrun flag.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wp       <= '0;
      rp       <= '0;
      ring_cnt <= '0;
      underrun <= 1'b0;
    end else begin
      if (pop && !head_vld) underrun <= 1'b1;
      if (line_start) begin
        wp       <= '0;
        rp       <= '0;
        ring_cnt <= '0;
      end else begin
        if (push)   wp <= wp + LA_W'(1);
        if (pop_ok) rp <= rp + LA_W'(1);
        case ({push, pop_ok})
          2'b10:   ring_cnt <= ring_cnt + (LA_W + 1)'(1);
          2'b01:   ring_cnt <= ring_cnt - (LA_W + 1)'(1);
          default: ring_cnt <= ring_cnt;
        endcase
      end
    end
  end

  // ---------------- pixel maths ----------------
  logic [11:0]     y12;
  logic [11:0]     ext_half;
  logic [11:0]     top;
  logic [11:0]     bot;
  logic [11:0]     dy;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   uv_full;
  logic            hit;
  logic [UV_W-1:0] uv_c;
  logic [TEX_W-1:0] tex_c;

  assign y12 = 12'(row >> RS_SH);

  // Wall span test and texture v; anything off the wall (sky, floor, blank) reports uv=0, tex=0.
  always_comb begin
    ext_half = 12'(head.half_h);
    top      = (ext_half >= CENTER_L) ? 12'd0 : (CENTER_L - ext_half);
    bot      = CENTER_L + ext_half;
    dy       = y12 - top;
    prod     = PW'(dy) * PW'(head.uv_step);
    uv_full  = prod >> UV_FRAC;
    hit      = in_display && head_vld && (ext_half != 12'd0) && (y12 >= top) && (y12 < bot);
    uv_c     = '0;
    tex_c    = '0;
    if (hit) begin
      tex_c = head.tex_id;
      uv_c  = (uv_full > UV_MAX) ? UV_W'(UV_MAX) : uv_full[UV_W-1:0];
    end
  end

  logic             s1_vld;
  logic             s1_inside;
  logic [UV_W-1:0]  s1_uv;
  logic [TEX_W-1:0] s1_tex;

  // Stage 1: capture the lookup result on the pixel strobe.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_vld    <= 1'b0;
      s1_inside <= 1'b0;
      s1_uv     <= '0;
      s1_tex    <= '0;
    end else begin
      s1_vld <= pix_en;
      if (pix_en) begin
        s1_inside <= hit;
        s1_uv     <= uv_c;
        s1_tex    <= tex_c;
      end
    end
  end

  // Stage 2: output register; values hold between px_valid pulses.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      px_valid  <= 1'b0;
      px_inside <= 1'b0;
      px_uv     <= '0;
      px_tex    <= '0;
    end else begin
      px_valid <= s1_vld;
      if (s1_vld) begin
        px_inside <= s1_inside;
        px_uv     <= s1_uv;
        px_tex    <= s1_tex;
      end
    end
  end

endmodule

// File: tb/tb_gpu_column_renderer.sv
// Directed sequence with random column records, checked against an arithmetic model of the renderer.
module tb_gpu_column_renderer;
  import gpu_pkg::*;

  logic               clk;
  logic               clr;
  logic               pix_en;
  logic               line_start;
  logic               frame_start;
  logic               in_display;
  logic [9:0]         row;
  logic [9:0]         column;
  logic               wr_en;
  logic [8:0]         wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic               swap_req;
  logic               swap_pending;
  logic               swap_ack;
  logic               px_valid;
  logic               px_inside;
  logic [UV_W-1:0]    px_uv;
  logic [TEX_W-1:0]   px_tex;
  logic               underrun;

  gpu_column_renderer dut (
    .clk          (clk),
    .clr          (clr),
    .pix_en       (pix_en),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .in_display   (in_display),
    .row          (row),
    .column       (column),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .swap_ack     (swap_ack),
    .px_valid     (px_valid),
    .px_inside    (px_inside),
    .px_uv        (px_uv),
    .px_tex       (px_tex),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int max_cnt = 0;

  // Reference state: both banks as the CPU sees them, and which one is on screen.
  logic [ENTRY_W-1:0] bank_m [2][320];
  bit                 front_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(dut.ring_cnt) > max_cnt) max_cnt = int'(dut.ring_cnt);
  endtask

  // Wall maths straight from the rules: y=row/2, top=max(0,120-h), inside for top<=y<120+h.
  function automatic void model_px(input logic [ENTRY_W-1:0] e, input int r, input bit disp,
                                   output bit ins, output int uv, output int tex);
    int half, step, y, top;
    half = int'(e[15:8]);
    step = int'(e[7:0]);
    y    = r / 2;
    top  = 120 - half;
    if (top < 0) top = 0;
    ins  = disp && (half != 0) && (y >= top) && (y < 120 + half);
    uv   = ins ? ((y - top) * step) / 16 : 0;
    if (uv > 63) uv = 63;
    tex  = ins ? int'(e[17:16]) : 0;
  endfunction

  task automatic pix(input int r, input int c, input bit disp, input bit check);
    bit ins;
    int uv, tex;
    pix_en = 1'b1; row = 10'(r); column = 10'(c); in_display = disp;
    tick();
    pix_en = 1'b0;
    tick();
    if (check) begin
      model_px(bank_m[front_m][c / 2], r, disp, ins, uv, tex);
      chk("px_valid", 32'(px_valid), 32'd1);
      chk("px_inside", 32'(px_inside), 32'(ins));
      chk("px_uv", 32'(px_uv), uv);
      chk("px_tex", 32'(px_tex), tex);
    end
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic render_line(input int r, input int ncols);
    pulse_line();
    repeat (16) tick();
    for (int c = 0; c < ncols; c++) pix(r, c, 1'b1, 1'b1);
  endtask

  task automatic write_col(input int addr, input logic [ENTRY_W-1:0] d);
    wr_en = 1'b1; wr_addr = 9'(addr); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (addr < 320) bank_m[~front_m][addr] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_px_valid"}, 32'(px_valid), 32'd0);
    chk({tag, "_px_inside"}, 32'(px_inside), 32'd0);
    chk({tag, "_px_uv"}, 32'(px_uv), 32'd0);
    chk({tag, "_px_tex"}, 32'(px_tex), 32'd0);
    chk({tag, "_swap_pending"}, 32'(swap_pending), 32'd0);
    chk({tag, "_swap_ack"}, 32'(swap_ack), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  function automatic logic [ENTRY_W-1:0] rand_entry();
    return ENTRY_W'($urandom);
  endfunction

  initial begin
    logic [ENTRY_W-1:0] e;
    clr = 1'b0; pix_en = 1'b0; line_start = 1'b0; frame_start = 1'b0; in_display = 1'b0;
    row = '0; column = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    front_m = 1'b0;

    // 1: reset holds everything at zero whatever the inputs do
    for (int i = 0; i < 6; i++) begin
      pix_en = 1'($urandom); line_start = 1'($urandom); frame_start = 1'($urandom);
      swap_req = 1'($urandom); in_display = 1'($urandom);
      row = 10'($urandom); column = 10'($urandom);
      tick();
      chk_all_zero("reset");
    end
    pix_en = 1'b0; line_start = 1'b0; frame_start = 1'b0; swap_req = 1'b0; in_display = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    pix(200, 0, 1'b1, 1'b0);
    chk("idle_px_valid", 32'(px_valid), 32'd1);
    chk("idle_px_inside", 32'(px_inside), 32'd0);
    pix(200, 4, 1'b0, 1'b0);
    chk("blank_px_valid", 32'(px_valid), 32'd1);
    chk("blank_px_inside", 32'(px_inside), 32'd0);
    chk("blank_px_uv", 32'(px_uv), 32'd0);
    chk("idle_underrun", 32'(underrun), 32'd0);

    // 2: fill back bank, swap on frame_start, render full line
    for (int c = 0; c < 320; c++) begin
      e = (c == 5) ? {2'd2, 8'd40, 8'd16} : rand_entry();
      write_col(c, e);
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("req_pending", 32'(swap_pending), 32'd1);
    chk("req_no_ack", 32'(swap_ack), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    front_m = ~front_m;
    chk("swap_ack", 32'(swap_ack), 32'd1);
    chk("swap_pending_clr", 32'(swap_pending), 32'd0);
    tick();
    chk("swap_ack_1clk", 32'(swap_ack), 32'd0);
    max_cnt = 0;
    render_line(200, 640);
    chk("line_underrun", 32'(underrun), 32'd0);
    chk("ring_max_le_8", 32'(max_cnt <= 8), 32'd1);
    render_line(200, 11);
    chk("col10_inside", 32'(px_inside), 32'd1);
    chk("col10_uv", 32'(px_uv), 32'd20);
    chk("col10_tex", 32'(px_tex), 32'd2);
    render_line(200, 12);
    chk("col11_inside", 32'(px_inside), 32'd1);
    chk("col11_uv", 32'(px_uv), 32'd20);
    render_line(150, 11);
    chk("row150_inside", 32'(px_inside), 32'd0);

    // 3: same-cycle request swaps at once; a repeated request gives one toggle
    for (int c = 0; c < 320; c++) write_col(c, rand_entry());
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    front_m = ~front_m;
    chk("same_cycle_ack", 32'(swap_ack), 32'd1);
    chk("same_cycle_pending", 32'(swap_pending), 32'd0);
    render_line($urandom_range(0, 479), 640);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("double_req_pending", 32'(swap_pending), 32'd1);
    e = rand_entry();
    frame_start = 1'b1;
    write_col(7, e);
    frame_start = 1'b0;
    front_m = ~front_m;
    chk("double_req_ack", 32'(swap_ack), 32'd1);
    tick();
    chk("double_req_ack_1clk", 32'(swap_ack), 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("no_req_no_ack", 32'(swap_ack), 32'd0);
    write_col(330, rand_entry());
    render_line($urandom_range(0, 479), 640);
    chk("line2_underrun", 32'(underrun), 32'd0);

    // 5: pixels at full clock rate right after line_start starve the ring
    pulse_line();
    for (int c = 0; c < 40; c++) begin
      pix_en = 1'b1; column = 10'(c); in_display = 1'b1;
      tick();
    end
    pix_en = 1'b0;
    tick();
    tick();
    chk("underrun_set", 32'(underrun), 32'd1);
    pulse_line();
    tick();
    chk("underrun_sticky", 32'(underrun), 32'd1);

    // 6: reset mid-line, then the next line renders from column 0
    pulse_line();
    repeat (16) tick();
    for (int c = 0; c < 300; c++) pix(260, c, 1'b1, 1'b1);
    pix_en = 1'b1; column = 10'd300; in_display = 1'b1;
    #2;
    clr = 1'b0;
    #1;
    chk_all_zero("midline_clr");
    pix_en = 1'b0;
    tick();
    clr = 1'b1;
    front_m = 1'b0;
    tick();
    render_line($urandom_range(0, 479), 2);
    chk("after_clr_underrun", 32'(underrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
